// File: rtl/ntt_host_sequencer_pkg.sv
// Shared definitions for the NTT1024 host sequencer: core opcodes and default sizing.
package ntt_host_sequencer_pkg;

   typedef enum logic [4:0] {
      OP_NOP        = 5'b00000,
      OP_LOAD_PARAM = 5'b00001,
      OP_LOAD_W     = 5'b00010,
      OP_LOAD_DATA  = 5'b00011,
      OP_NTT        = 5'b00100,
      OP_INTT       = 5'b00111,
      OP_READ_INTT  = 5'b01000,
      OP_PWMUL      = 5'b01010,
      OP_READ       = 5'b01011
   } opcode_e;

   localparam int SEQ_DW       = 32;
   localparam int SEQ_OPW      = 5;
   localparam int SEQ_LENW     = 13;
   localparam int SEQ_WAIT_MAX = 65535;
   localparam int WD_W         = 16;

endpackage

// File: rtl/ntt_seq_counter.sv
// Loadable down-counter with a zero flag; decrements saturate at zero.
module ntt_seq_counter #(
   parameter int W = 13
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] count_o,
   output logic         zero_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/ntt_host_sequencer.sv
// Host-port sequencer for the NTT1024 core: turns queued commands into the
// opcode pulse / burst / idle gap / done-wait cycle pattern the core consumes.
module ntt_host_sequencer
   import ntt_host_sequencer_pkg::*;
#(
   parameter int DW       = SEQ_DW,
   parameter int OPW      = SEQ_OPW,
   parameter int LENW     = SEQ_LENW,
   parameter int WAIT_MAX = SEQ_WAIT_MAX
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [OPW-1:0]  cmd_op,
   input  logic [LENW-1:0] cmd_len,
   input  logic            cmd_strobe,
   input  logic            cmd_wait,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [DW-1:0]   s_data,
   output logic [OPW-1:0]  OP_CODE,
   output logic            din_valid,
   output logic [DW-1:0]   din0,
   input  logic            done,
   output logic            busy,
   output logic            timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OP,
      S_STREAM,
      S_GAP,
      S_WAIT
   } state_e;

   state_e           state_q, state_d;
   logic             strobe_q, strobe_d;
   logic             wait_q, wait_d;
   logic             done_seen_q, done_seen_d;
   logic             timeout_q, timeout_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             s_ready_q, s_ready_d;
   logic             din_valid_q, din_valid_d;
   logic [OPW-1:0]   op_code_q, op_code_d;
   logic [DW-1:0]    din0_q, din0_d;

   logic             accept;
   logic             in_burst;
   logic             feed;
   logic [LENW-1:0]  burst_cnt;
   logic [LENW-1:0]  burst_next;
   logic             burst_zero;
   logic             wd_load;
   logic             wd_dec;
   logic [WD_W-1:0]  wd_cnt;
   logic             wd_zero;
   logic             unused_wd_bits;

   // The output registers run one cycle behind the load decision: a word
   // taken during OP/STREAM appears on din0 in the following cycle.
   assign accept   = (state_q == S_IDLE) && cmd_ready_q && cmd_valid;
   assign in_burst = (state_q == S_OP) || (state_q == S_STREAM);
   assign feed     = in_burst && !burst_zero && (strobe_q || (s_valid && s_ready_q));

   always_comb begin
      burst_next = burst_cnt;
      if (accept) begin
         burst_next = cmd_len;
      end else if (feed) begin
         burst_next = burst_cnt - 1'b1;
      end
   end

   assign wd_load = (state_q == S_GAP) && wait_q;
   assign wd_dec  = (state_q == S_WAIT);

   ntt_seq_counter #(.W(LENW)) u_burst_cnt (
      .clk_i      (clk),
      .rst_i      (reset),
      .load_i     (accept),
      .load_val_i (cmd_len),
      .dec_i      (feed),
      .count_o    (burst_cnt),
      .zero_o     (burst_zero)
   );

   ntt_seq_counter #(.W(WD_W)) u_watchdog (
      .clk_i      (clk),
      .rst_i      (reset),
      .load_i     (wd_load),
      .load_val_i (WD_W'(WAIT_MAX - 1)),
      .dec_i      (wd_dec),
      .count_o    (wd_cnt),
      .zero_o     (wd_zero)
   );

   assign unused_wd_bits = ^wd_cnt;

   always_comb begin
      state_d     = state_q;
      strobe_d    = strobe_q;
      wait_d      = wait_q;
      done_seen_d = done_seen_q;
      timeout_d   = timeout_q;
      op_code_d   = OPW'(OP_NOP);
      din_valid_d = 1'b0;
      din0_d      = '0;

      if ((state_q != S_IDLE) && done) begin
         done_seen_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d     = S_OP;
               strobe_d    = cmd_strobe;
               wait_d      = cmd_wait;
               done_seen_d = 1'b0;
               timeout_d   = 1'b0;
               op_code_d   = cmd_op;
               din_valid_d = cmd_strobe;
            end
         end
         S_OP:     state_d = burst_zero ? S_GAP : S_STREAM;
         S_STREAM: if (burst_zero) state_d = S_GAP;
         S_GAP:    state_d = wait_q ? S_WAIT : S_IDLE;
         S_WAIT: begin
            if (done_seen_q || done) begin
               state_d = S_IDLE;
            end else if (wd_zero) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default:  state_d = S_IDLE;
      endcase

      if (feed) begin
         din_valid_d = 1'b1;
         din0_d      = strobe_q ? '0 : s_data;
      end

      cmd_ready_d = (state_d == S_IDLE);
      s_ready_d   = ((state_d == S_OP) || (state_d == S_STREAM)) && !strobe_d &&
                    (burst_next != '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         strobe_q    <= 1'b0;
         wait_q      <= 1'b0;
         done_seen_q <= 1'b0;
         timeout_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
         s_ready_q   <= 1'b0;
         din_valid_q <= 1'b0;
         op_code_q   <= '0;
         din0_q      <= '0;
      end else begin
         state_q     <= state_d;
         strobe_q    <= strobe_d;
         wait_q      <= wait_d;
         done_seen_q <= done_seen_d;
         timeout_q   <= timeout_d;
         cmd_ready_q <= cmd_ready_d;
         s_ready_q   <= s_ready_d;
         din_valid_q <= din_valid_d;
         op_code_q   <= op_code_d;
         din0_q      <= din0_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign s_ready   = s_ready_q;
   assign OP_CODE   = op_code_q;
   assign din_valid = din_valid_q;
   assign din0      = din0_q;
   assign busy      = (state_q != S_IDLE);
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_ntt_host_sequencer.sv
// Scoreboard bench for ntt_host_sequencer: stimulus pushes expected beats and
// command records; a negedge monitor pops and compares what the core port shows.
module tb_ntt_host_sequencer;
   import ntt_host_sequencer_pkg::*;

   localparam int DW      = 32;
   localparam int OPW     = 5;
   localparam int LENW    = 13;
   localparam int TB_WAIT = 600;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [OPW-1:0]  cmd_op = '0;
   logic [LENW-1:0] cmd_len = '0;
   logic            cmd_strobe = 1'b0;
   logic            cmd_wait = 1'b0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [DW-1:0]   s_data = '0;
   logic [OPW-1:0]  OP_CODE;
   logic            din_valid;
   logic [DW-1:0]   din0;
   logic            done = 1'b0;
   logic            busy;
   logic            timeout;

   typedef struct {
      logic [4:0] op;
      int         len;
      bit         strobe;
      bit         wt;
      int         exp_busy;   // 0: derive from len and observed stalls
      bit         exp_to;
   } cmd_t;

   cmd_t        cmd_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] src_q[$];
   logic [31:0] words_q[$];

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int n_issued = 0;
   int beats_seen = 0;
   int stall_mode = 0;
   bit hs_pending = 1'b0;

   logic [4:0] op_list [8] = '{OP_LOAD_PARAM, OP_LOAD_W, OP_LOAD_DATA, OP_NTT,
                               OP_INTT, OP_READ_INTT, OP_PWMUL, OP_READ};

   ntt_host_sequencer #(
      .DW(DW), .OPW(OPW), .LENW(LENW), .WAIT_MAX(TB_WAIT)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_len(cmd_len), .cmd_strobe(cmd_strobe), .cmd_wait(cmd_wait),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .OP_CODE(OP_CODE), .din_valid(din_valid), .din0(din0),
      .done(done), .busy(busy), .timeout(timeout)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic abort_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench stopped: bounded wait expired");
   endtask

   task automatic issue(input logic [4:0] op, input int len, input bit strobe, input bit wt,
                        input int exp_busy, input bit exp_to, input int mode);
      cmd_t        c;
      int          guard;
      logic [31:0] w;
      guard = 0;
      while (!cmd_ready && guard < 10000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
         abort_run();
      end
      c.op = op; c.len = len; c.strobe = strobe; c.wt = wt;
      c.exp_busy = exp_busy; c.exp_to = exp_to;
      cmd_q.push_back(c);
      stall_mode = mode;
      if (strobe) begin
         for (int i = 0; i <= len; i++) exp_q.push_back(32'd0);
      end else begin
         for (int i = 0; i < len; i++) begin
            w = (words_q.size() > 0) ? words_q.pop_front() : $urandom;
            exp_q.push_back(w);
            src_q.push_back(w);
         end
      end
      n_issued++;
      cmd_valid = 1'b1; cmd_op = op; cmd_len = LENW'(len);
      cmd_strobe = strobe; cmd_wait = wt;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      while (done_cnt < n_issued && guard < 10000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (done_cnt < n_issued) begin
         chk("completion_wait", 64'(done_cnt), 64'(n_issued));
         abort_run();
      end
   endtask

   // Data source: presents the head of src_q, drops it after each handshake.
   initial forever begin
      @(negedge clk);
      hs_pending = s_valid && s_ready;
   end

   initial begin : source
      int c;
      bit stall;
      c = 0;
      forever begin
         @(posedge clk);
         if (hs_pending && src_q.size() > 0) void'(src_q.pop_front());
         #1;
         c++;
         case (stall_mode)
            0:       stall = 1'b0;
            1:       stall = (c % 7 == 0);
            default: stall = ($urandom_range(0, 3) == 0);
         endcase
         s_valid = (src_q.size() > 0) && !stall;
         s_data  = (src_q.size() > 0) ? src_q[0] : 32'd0;
      end
   end

   initial begin : monitor
      cmd_t        cur;
      int          beats_left, stalls, cyc, sready_seen, exp_b;
      bit          active, gap_next;
      logic [31:0] e;
      beats_left = 0; stalls = 0; cyc = 0; sready_seen = 0;
      active = 1'b0; gap_next = 1'b0;
      cur.op = '0; cur.len = 0; cur.strobe = 0; cur.wt = 0; cur.exp_busy = 0; cur.exp_to = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            active = 1'b0; gap_next = 1'b0; beats_left = 0;
         end else begin
            if (active && busy) cyc++;
            if (gap_next) begin
               chk("gap_idle", {din_valid, OP_CODE}, 64'd0);
               gap_next = 1'b0;
            end else if (OP_CODE != '0) begin
               if (cmd_q.size() == 0) begin
                  chk("unexpected_op", 64'(OP_CODE), 64'd0);
               end else begin
                  cur = cmd_q.pop_front();
                  active = 1'b1; cyc = 1; stalls = 0; sready_seen = 0;
                  chk("op_code", 64'(OP_CODE), 64'(cur.op));
                  chk("op_din_valid", 64'(din_valid), 64'(cur.strobe));
                  chk("op_din0", 64'(din0), 64'd0);
                  if (cur.strobe && din_valid && exp_q.size() > 0) void'(exp_q.pop_front());
                  beats_left = cur.len;
                  if (cur.len == 0) gap_next = 1'b1;
               end
            end else if (active && beats_left > 0) begin
               if (din_valid) begin
                  if (exp_q.size() == 0) begin
                     chk("din_unexpected", 64'd1, 64'd0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("din0", 64'(din0), 64'(e));
                  end
                  beats_left--;
                  beats_seen++;
                  if (beats_left == 0) gap_next = 1'b1;
               end else begin
                  stalls++;
               end
            end else if (din_valid) begin
               chk("stray_din_valid", 64'd1, 64'd0);
            end
            if (active && cur.strobe && s_ready) sready_seen++;
            if (active && !busy) begin
               exp_b = (cur.exp_busy != 0) ? cur.exp_busy : cur.len + stalls + 2;
               chk("busy_cycles", 64'(cyc), 64'(exp_b));
               chk("timeout_flag", 64'(timeout), 64'(cur.exp_to));
               if (cur.strobe) chk("strobe_s_ready", 64'(sready_seen), 64'd0);
               $display("txn op=%0d len=%0d strobe=%0d wait=%0d cycles=%0d stalls=%0d",
                        cur.op, cur.len, cur.strobe, cur.wt, cyc, stalls);
               active = 1'b0;
               done_cnt++;
            end
         end
      end
   end

   initial begin : stimulus
      int guard;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_op_code", 64'(OP_CODE), 64'd0);
      chk("rst_din", {din_valid, din0}, 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_busy_timeout", {busy, timeout}, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset", 64'(cmd_ready), 64'd1);
      chk("busy_after_reset", 64'(busy), 64'd0);

      words_q = '{32'h1, 32'h3001, 32'h2FFE};
      issue(OP_LOAD_PARAM, 3, 0, 0, 0, 0, 0);
      wait_done();
      issue(OP_LOAD_DATA, 2048, 0, 0, 0, 0, 1);
      wait_done();
      issue(OP_READ, 41, 1, 0, 0, 0, 0);
      wait_done();

      // done arrives in the 500th busy cycle
      issue(OP_NTT, 0, 0, 1, 500, 0, 0);
      repeat (499) @(posedge clk);
      #1 done = 1'b1;
      @(posedge clk); #1 done = 1'b0;
      wait_done();

      issue(OP_NTT, 0, 0, 1, TB_WAIT + 2, 1, 0);
      wait_done();

      // done coincident with OP must still release the wait immediately
      issue(OP_INTT, 5, 1, 1, 8, 0, 0);
      chk("timeout_clear", 64'(timeout), 64'd0);
      done = 1'b1;
      @(posedge clk); #1 done = 1'b0;
      wait_done();

      beats_seen = 0;
      issue(OP_LOAD_W, 3552, 0, 0, 0, 0, 2);
      guard = 0;
      while (beats_seen < 1000 && guard < 10000) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("reached_word_1000", 64'(beats_seen >= 1000), 64'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_op_code", 64'(OP_CODE), 64'd0);
      chk("mid_rst_din", {din_valid, din0}, 64'd0);
      chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
      chk("mid_rst_busy_ready", {busy, cmd_ready}, 64'd0);
      cmd_q.delete(); exp_q.delete(); src_q.delete();
      n_issued--;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      issue(OP_LOAD_W, 3552, 0, 0, 0, 0, 2);
      wait_done();

      for (int i = 0; i < 20; i++) begin
         issue(op_list[$urandom_range(0, 7)], $urandom_range(0, 40), 1'($urandom_range(0, 1)),
               0, 0, 0, 2);
      end
      wait_done();
      repeat (3) @(posedge clk);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
